// File: rtl/alignment_collector_pkg.sv
// Shared types and base codes for the traceback alignment collector.
// Base encoding follows the traceback unit: 3'b100 marks a gap, 3'b111 the null base.
package aln_pkg;

    localparam logic [2:0] BASE_GAP  = 3'b100;
    localparam logic [2:0] BASE_NULL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] q;
    } pair_t;

    function automatic logic is_null(pair_t p);
        return (p.r == BASE_NULL) && (p.q == BASE_NULL);
    endfunction

    function automatic logic is_gap(pair_t p);
        return (p.r == BASE_GAP) || (p.q == BASE_GAP);
    endfunction

endpackage

// File: rtl/alignment_collector_if.sv
// Forward-order pair stream from the collector to the result stage.
interface alignment_collector_if;

    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_r;
    logic [2:0] out_q;
    logic       out_last;

    modport master (
        output out_valid,
        output out_r,
        output out_q,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_r,
        input  out_q,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/alignment_collector_pair_stack.sv
// Register-array LIFO; top is read combinationally from the entry below the pointer.
module pair_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 6,
    localparam int unsigned CntW = $clog2(DEPTH + 1),
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    top,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [CntW-1:0] count_q;
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            do_push;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clear && !rst;
    assign wr_idx  = IdxW'(count_q);
    assign rd_idx  = IdxW'(count_q - CntW'(1));
    assign top     = mem_q[rd_idx];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (do_push) begin
            count_q <= count_q + CntW'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CntW'(1);
        end
    end

    // Storage needs no reset: entries are only read below the pointer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/alignment_collector.sv
// Stacks traceback pairs (emitted end-to-start), replays them in forward order over a
// valid/ready stream, and keeps match/mismatch/gap statistics for the result stage.
module alignment_collector
    import aln_pkg::*;
#(
    parameter int unsigned L     = 8,
    parameter int unsigned DEPTH = 2 * L,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_traceback,
    input  logic [2:0]                   tb_r,
    input  logic [2:0]                   tb_q,
    input  logic                         tb_finish,
    alignment_collector_if.master        out_if,
    output logic                         done,
    output logic [CW-1:0]                aln_len,
    output logic [CW-1:0]                match_cnt,
    output logic [CW-1:0]                mismatch_cnt,
    output logic [CW-1:0]                gap_cnt,
    output logic                         overflow
);

    state_e          state_q, state_d;
    pair_t           in_pair;
    pair_t           top_pair;
    logic [CW-1:0]   stk_count;
    logic            stk_full, stk_empty;
    logic            push, pop, clear, clr_stats, set_ovf;
    logic            drain_act;

    logic [CW-1:0]   aln_len_q, match_q, mismatch_q, gap_q;
    logic            overflow_q;

    assign in_pair = '{r: tb_r, q: tb_q};

    pair_stack #(
        .DEPTH (DEPTH),
        .W     (6)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (in_pair),
        .top   (top_pair),
        .count (stk_count),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        clr_stats = 1'b0;
        set_ovf   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_traceback) begin
                    state_d   = COLLECT;
                    clear     = 1'b1;
                    clr_stats = 1'b1;
                end
            end
            COLLECT: begin
                if (!start_traceback) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end else begin
                    if (!is_null(in_pair)) begin
                        if (!stk_full) push    = 1'b1;
                        else           set_ovf = 1'b1;
                    end
                    if (tb_finish) state_d = DRAIN;
                end
            end
            // Drain ignores start_traceback; only reset can cut it short.
            DRAIN: begin
                if (stk_empty) begin
                    state_d = DONE;
                end else if (out_if.out_ready) begin
                    pop = 1'b1;
                    if (stk_count == CW'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (!start_traceback) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign drain_act        = (state_q == DRAIN) && !stk_empty;
    assign out_if.out_valid = drain_act;
    assign out_if.out_r     = drain_act ? top_pair.r : BASE_NULL;
    assign out_if.out_q     = drain_act ? top_pair.q : BASE_NULL;
    assign out_if.out_last  = drain_act && (stk_count == CW'(1));
    assign done             = (state_q == DONE);

    // Statistics survive an abort; they are cleared only when a new session starts.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            aln_len_q  <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            gap_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                aln_len_q <= aln_len_q + CW'(1);
                if (is_gap(in_pair))          gap_q      <= gap_q + CW'(1);
                else if (in_pair.r == in_pair.q) match_q <= match_q + CW'(1);
                else                          mismatch_q <= mismatch_q + CW'(1);
            end
            if (set_ovf) overflow_q <= 1'b1;
        end
    end

    assign aln_len      = aln_len_q;
    assign match_cnt    = match_q;
    assign mismatch_cnt = mismatch_q;
    assign gap_cnt      = gap_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_alignment_collector.sv
// Directed bench for alignment_collector: LIFO replay order, statistics, backpressure,
// abort, overflow, held finish and mid-drain reset.
module tb_alignment_collector;

    localparam int unsigned L     = 8;
    localparam int unsigned DEPTH = 2 * L;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start_traceback;
    logic [2:0]    tb_r, tb_q;
    logic          tb_finish;
    logic          done, overflow;
    logic [CW-1:0] aln_len, match_cnt, mismatch_cnt, gap_cnt;

    alignment_collector_if out_if ();

    alignment_collector #(
        .L     (L),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_traceback (start_traceback),
        .tb_r            (tb_r),
        .tb_q            (tb_q),
        .tb_finish       (tb_finish),
        .out_if          (out_if),
        .done            (done),
        .aln_len         (aln_len),
        .match_cnt       (match_cnt),
        .mismatch_cnt    (mismatch_cnt),
        .gap_cnt         (gap_cnt),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [5:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One traceback cycle; non-null pairs enter the LIFO model while it has room.
    task automatic send(input logic [2:0] r, input logic [2:0] q, input logic fin);
        tb_r      = r;
        tb_q      = q;
        tb_finish = fin;
        if (!(r == 3'b111 && q == 3'b111) && exp_q.size() < DEPTH) exp_q.push_front({r, q});
        tick();
        tb_r      = 3'b111;
        tb_q      = 3'b111;
        tb_finish = 1'b0;
    endtask

    task automatic stats(input string tag, input int len, input int m, input int mm,
                         input int g, input logic ovf);
        chk({tag, " aln_len"}, aln_len, len);
        chk({tag, " match_cnt"}, match_cnt, m);
        chk({tag, " mismatch_cnt"}, mismatch_cnt, mm);
        chk({tag, " gap_cnt"}, gap_cnt, g);
        chk({tag, " overflow"}, overflow, ovf);
    endtask

    // Drains against the model; ready is dropped for stall_len cycles after stall_at transfers.
    task automatic drain(input string tag, input int stall_at, input int stall_len);
        int   moved   = 0;
        int   stalled = 0;
        int   budget  = 0;
        logic rdy;
        while (exp_q.size() > 0 && budget < 200) begin
            budget++;
            rdy = !(moved == stall_at && stalled < stall_len);
            out_if.out_ready = rdy;
            chk({tag, " out_valid"}, out_if.out_valid, 1);
            chk({tag, " out_pair"}, {out_if.out_r, out_if.out_q}, exp_q[0]);
            chk({tag, " out_last"}, out_if.out_last, exp_q.size() == 1);
            if (!rdy) stalled++;
            tick();
            if (rdy) begin
                void'(exp_q.pop_front());
                moved++;
            end
        end
        out_if.out_ready = 1'b1;
        chk({tag, " drain_budget"}, exp_q.size(), 0);
        chk({tag, " valid_after"}, out_if.out_valid, 0);
        chk({tag, " out_r_after"}, out_if.out_r, 3'b111);
        chk({tag, " done"}, done, 1);
    endtask

    initial begin
        logic [2:0] r, q;

        rst              = 1'b1;
        start_traceback  = 1'b0;
        tb_r             = 3'b111;
        tb_q             = 3'b111;
        tb_finish        = 1'b0;
        out_if.out_ready = 1'b1;
        tick();
        tick();
        chk("rst out_valid", out_if.out_valid, 0);
        chk("rst out_last", out_if.out_last, 0);
        chk("rst out_r", out_if.out_r, 3'b111);
        chk("rst out_q", out_if.out_q, 3'b111);
        chk("rst done", done, 0);
        stats("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // 1: diagonal run of matches.
        start_traceback = 1'b1;
        tick();
        send(3'd0, 3'd0, 0);
        send(3'd1, 3'd1, 0);
        send(3'd2, 3'd2, 0);
        send(3'd3, 3'd3, 0);
        send(3'd5, 3'd5, 0);
        send(3'd6, 3'd6, 0);
        send(3'd0, 3'd0, 0);
        send(3'd1, 3'd1, 1);
        stats("s1", 8, 8, 0, 0, 0);
        drain("s1", -1, 0);
        tick();
        chk("s1 done_held", done, 1);
        start_traceback = 1'b0;
        tick();
        chk("s1 done_clear", done, 0);

        // 2: mixed path with gaps and a mismatch.
        start_traceback = 1'b1;
        tick();
        send(3'd1, 3'd1, 0);
        send(3'd2, 3'd4, 0);
        send(3'd4, 3'd3, 0);
        send(3'd5, 3'd6, 0);
        send(3'd0, 3'd0, 1);
        stats("s2", 5, 2, 1, 2, 0);
        drain("s2", -1, 0);
        start_traceback = 1'b0;
        tick();

        // 3: backpressure mid-drain.
        start_traceback = 1'b1;
        tick();
        send(3'd0, 3'd0, 0);
        send(3'd1, 3'd1, 0);
        send(3'd2, 3'd2, 0);
        send(3'd3, 3'd3, 0);
        send(3'd5, 3'd5, 0);
        send(3'd6, 3'd6, 0);
        send(3'd0, 3'd0, 0);
        send(3'd1, 3'd1, 1);
        drain("s3", 3, 3);
        start_traceback = 1'b0;
        tick();

        // 4: abort after three pairs, then a zero-pair session.
        start_traceback = 1'b1;
        tick();
        send(3'd1, 3'd1, 0);
        send(3'd2, 3'd3, 0);
        send(3'd4, 3'd4, 0);
        start_traceback = 1'b0;
        chk("s4 valid_collect", out_if.out_valid, 0);
        tick();
        chk("s4 valid_idle", out_if.out_valid, 0);
        chk("s4 done_idle", done, 0);
        stats("s4 kept", 3, 1, 1, 1, 0);
        exp_q.delete();
        start_traceback = 1'b1;
        tick();
        stats("s4 restart", 0, 0, 0, 0, 0);
        send(3'b111, 3'b111, 1);
        chk("s4 zero valid", out_if.out_valid, 0);
        chk("s4 zero done_early", done, 0);
        tick();
        chk("s4 zero valid_done", out_if.out_valid, 0);
        chk("s4 zero done", done, 1);
        start_traceback = 1'b0;
        tick();

        // 5: overflow, 17 pairs into a 16-deep stack.
        start_traceback = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            r = {1'b0, i[1:0]};
            q = {1'b0, i[3:2]};
            send(r, q, i == 16);
        end
        stats("s5", 16, 4, 12, 0, 1);
        drain("s5", -1, 0);
        start_traceback = 1'b0;
        tick();

        // 6a: finish held for four cycles; later finish pulses in DONE ignored.
        start_traceback = 1'b1;
        tick();
        send(3'd1, 3'd1, 0);
        out_if.out_ready = 1'b0;
        tb_r      = 3'd2;
        tb_q      = 3'd2;
        tb_finish = 1'b1;
        exp_q.push_front({3'd2, 3'd2});
        for (int i = 0; i < 4; i++) tick();
        stats("s6 held", 2, 2, 0, 0, 0);
        tb_r      = 3'b111;
        tb_q      = 3'b111;
        tb_finish = 1'b0;
        drain("s6 held", -1, 0);
        tb_r      = 3'd3;
        tb_q      = 3'd3;
        tb_finish = 1'b1;
        tick();
        tick();
        chk("s6 done_pulses", done, 1);
        chk("s6 len_pulses", aln_len, 2);
        tb_r            = 3'b111;
        tb_q            = 3'b111;
        tb_finish       = 1'b0;
        start_traceback = 1'b0;
        tick();
        chk("s6 done_clear", done, 0);

        // 6b: reset in the middle of a drain.
        start_traceback = 1'b1;
        tick();
        send(3'd1, 3'd2, 0);
        send(3'd3, 3'd3, 0);
        send(3'd5, 3'd4, 1);
        chk("s6 rst pre_valid", out_if.out_valid, 1);
        tick();
        rst             = 1'b1;
        start_traceback = 1'b0;
        tick();
        rst = 1'b0;
        chk("s6 rst out_valid", out_if.out_valid, 0);
        chk("s6 rst out_r", out_if.out_r, 3'b111);
        chk("s6 rst done", done, 0);
        stats("s6 rst", 0, 0, 0, 0, 0);
        exp_q.delete();
        start_traceback = 1'b1;
        tick();
        send(3'b111, 3'b111, 1);
        chk("s6 rst ptr_empty", out_if.out_valid, 0);
        tick();
        chk("s6 rst done_after", done, 1);
        start_traceback = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
